// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one single-port BRAM between the fetch
// stage (read-only) and the program loader (read/write).  A boot FSM keeps
// fetch off until the loader signals completion.  In RUN, fetch has priority,
// and a starvation counter forces the loader in after STARVE_MAX consecutive
// fetch wins.  Read responses are steered back by a tag pipeline whose depth
// matches the BRAM read latency.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_BOOT | image being loaded; only the loader may access the BRAM
// S_RUN  | fetch enabled, fetch-priority arbitration with starve guard
module imem_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_done,
    output logic              running,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [RD_LAT-1:0] tag_v_q;
    logic [RD_LAT-1:0] tag_o_q;   // owner: 0 = fetch, 1 = loader
    logic              push_v;

    // State and starve-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_BOOT;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Next state, grants and starve-counter update.
    // Grants are additionally gated by rst so nothing reaches the BRAM while
    // reset is held, even though the FSM is already in BOOT.
    always_comb begin
        state_d  = state_q;
        starve_d = '0;
        f_gnt    = 1'b0;
        l_gnt    = 1'b0;
        case (state_q)
            S_BOOT: begin
                l_gnt = l_req;
                if (boot_done) state_d = S_RUN;
            end
            S_RUN: begin
                if (f_req && l_req) begin
                    if (starve_q == STARVE_TOP) l_gnt = 1'b1;
                    else                        f_gnt = 1'b1;
                end else begin
                    f_gnt = f_req;
                    l_gnt = l_req;
                end
                if (f_gnt && l_req)
                    starve_d = (starve_q == STARVE_TOP) ? starve_q : starve_q + 1'b1;
            end
            default: state_d = S_BOOT;
        endcase
        if (!rst) begin
            f_gnt = 1'b0;
            l_gnt = 1'b0;
        end
    end

    // BRAM port mux: granted requester drives the memory, otherwise all zero.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (f_gnt) begin
            mem_en   = 1'b1;
            mem_addr = f_addr;
        end else if (l_gnt) begin
            mem_en    = 1'b1;
            mem_we    = l_we;
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
        end
    end

    assign push_v = f_gnt | (l_gnt & ~l_we);

    // Tag pipeline: one entry per cycle, aligned with the BRAM read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_v_q <= '0;
            tag_o_q <= '0;
        end else begin
            tag_v_q[0] <= push_v;
            tag_o_q[0] <= l_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_o_q[i] <= tag_o_q[i-1];
            end
        end
    end

    assign running  = (state_q == S_RUN);
    assign f_rvalid = tag_v_q[RD_LAT-1] & ~tag_o_q[RD_LAT-1];
    assign l_rvalid = tag_v_q[RD_LAT-1] &  tag_o_q[RD_LAT-1];
    assign f_rdata  = mem_rdata;
    assign l_rdata  = mem_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: two instances (RD_LAT=1 and RD_LAT=2) share the same
// stimulus, each with its own write-first BRAM model and scoreboard queue.
module tb_imem_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic boot_done = 1'b0;
    logic f_req = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic l_req = 1'b0;
    logic l_we = 1'b0;
    logic [AW-1:0] l_addr = '0;
    logic [DW-1:0] l_wdata = '0;

    logic          running_a  [2];
    logic          f_gnt_a    [2];
    logic          f_rvalid_a [2];
    logic [DW-1:0] f_rdata_a  [2];
    logic          l_gnt_a    [2];
    logic          l_rvalid_a [2];
    logic [DW-1:0] l_rdata_a  [2];
    logic          mem_en_a   [2];
    logic          mem_we_a   [2];
    logic [AW-1:0] mem_addr_a [2];
    logic [DW-1:0] mem_wdata_a[2];
    logic [DW-1:0] mem_rdata_a[2];

    logic [DW-1:0] bram0 [32];
    logic [DW-1:0] bram1 [32];
    logic [DW-1:0] ref_mem [32];
    logic [DW-1:0] r0_s0, r1_s0, r1_s1;

    typedef struct packed {
        logic          own;
        logic [DW-1:0] d;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .rst(rst), .boot_done(boot_done), .running(running_a[0]),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt_a[0]),
        .f_rvalid(f_rvalid_a[0]), .f_rdata(f_rdata_a[0]),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt_a[0]), .l_rvalid(l_rvalid_a[0]), .l_rdata(l_rdata_a[0]),
        .mem_en(mem_en_a[0]), .mem_we(mem_we_a[0]), .mem_addr(mem_addr_a[0]),
        .mem_wdata(mem_wdata_a[0]), .mem_rdata(mem_rdata_a[0])
    );

    imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .STARVE_MAX(4)) u_dut2 (
        .clk(clk), .rst(rst), .boot_done(boot_done), .running(running_a[1]),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt_a[1]),
        .f_rvalid(f_rvalid_a[1]), .f_rdata(f_rdata_a[1]),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt_a[1]), .l_rvalid(l_rvalid_a[1]), .l_rdata(l_rdata_a[1]),
        .mem_en(mem_en_a[1]), .mem_we(mem_we_a[1]), .mem_addr(mem_addr_a[1]),
        .mem_wdata(mem_wdata_a[1]), .mem_rdata(mem_rdata_a[1])
    );

    initial begin
        for (int i = 0; i < 32; i++) begin
            bram0[i]   = 32'hA500_0000 | i;
            bram1[i]   = 32'hA500_0000 | i;
            ref_mem[i] = 32'hA500_0000 | i;
        end
    end

    // Write-first BRAM model, one read stage.
    always @(posedge clk) begin
        if (mem_en_a[0]) begin
            if (mem_we_a[0]) begin
                bram0[mem_addr_a[0]] <= mem_wdata_a[0];
                r0_s0 <= mem_wdata_a[0];
            end else begin
                r0_s0 <= bram0[mem_addr_a[0]];
            end
        end
    end

    // Write-first BRAM model, two read stages.
    always @(posedge clk) begin
        if (mem_en_a[1]) begin
            if (mem_we_a[1]) begin
                bram1[mem_addr_a[1]] <= mem_wdata_a[1];
                r1_s0 <= mem_wdata_a[1];
            end else begin
                r1_s0 <= bram1[mem_addr_a[1]];
            end
        end
        r1_s1 <= r1_s0;
    end

    assign mem_rdata_a[0] = r0_s0;
    assign mem_rdata_a[1] = r1_s1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sb_step(input int k);
        exp_t e;
        int   qs;
        qs = (k == 0) ? q0.size() : q1.size();
        if (f_rvalid_a[k] || l_rvalid_a[k]) begin
            chk($sformatf("one_rvalid%0d", k), 64'(f_rvalid_a[k] & l_rvalid_a[k]), 64'd0);
            if (qs == 0) begin
                chk($sformatf("rvalid_unexpected%0d", k), 64'(f_rvalid_a[k] | l_rvalid_a[k]), 64'd0);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("rvalid_owner%0d", k), 64'(l_rvalid_a[k]), 64'(e.own));
                chk($sformatf("rdata%0d", k),
                    64'(l_rvalid_a[k] ? l_rdata_a[k] : f_rdata_a[k]), 64'(e.d));
            end
        end
        if (f_gnt_a[k] || l_gnt_a[k]) begin
            chk($sformatf("one_gnt%0d", k), 64'(f_gnt_a[k] & l_gnt_a[k]), 64'd0);
            chk($sformatf("mem_en%0d", k), 64'(mem_en_a[k]), 64'd1);
            chk($sformatf("mem_addr%0d", k), 64'(mem_addr_a[k]),
                64'(f_gnt_a[k] ? f_addr : l_addr));
            if (f_gnt_a[k]) e = '{own: 1'b0, d: ref_mem[f_addr]};
            else            e = '{own: 1'b1, d: ref_mem[l_addr]};
            if (f_gnt_a[k] || !l_we) begin
                if (k == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end else if (mem_en_a[k]) begin
            chk($sformatf("mem_en_idle%0d", k), 64'(mem_en_a[k]), 64'd0);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            sb_step(0);
            sb_step(1);
            if (l_gnt_a[0] && l_we) ref_mem[l_addr] = l_wdata;
        end
    end

    task automatic do_load(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit done = 0;
        @(posedge clk); #1;
        l_req = 1'b1; l_we = we; l_addr = a; l_wdata = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (l_gnt_a[0]) begin
                done = 1;
                chk("load_mem_we", 64'(mem_we_a[0]), 64'(we));
                if (we) chk("load_mem_wdata", 64'(mem_wdata_a[0]), 64'(d));
            end
        end
        if (!done) chk("load_timeout", 64'(l_gnt_a[0]), 64'd1);
        @(posedge clk); #1;
        l_req = 1'b0; l_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with requests pending.
        f_req = 1'b1; f_addr = 5'd3; l_req = 1'b1;
        @(negedge clk);
        chk("rst_running", 64'(running_a[0]), 64'd0);
        chk("rst_f_gnt", 64'(f_gnt_a[0]), 64'd0);
        chk("rst_l_gnt", 64'(l_gnt_a[0]), 64'd0);
        chk("rst_mem_en", 64'(mem_en_a[0]), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr_a[0]), 64'd0);
        chk("rst_rvalid", 64'({f_rvalid_a[0], l_rvalid_a[0], f_rvalid_a[1], l_rvalid_a[1]}), 64'd0);
        @(posedge clk); #1;
        l_req = 1'b0;
        rst = 1'b1;

        // BOOT: fetch is held off.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("boot_f_gnt", 64'(f_gnt_a[0]), 64'd0);
            chk("boot_mem_en", 64'(mem_en_a[0]), 64'd0);
            chk("boot_running", 64'(running_a[0]), 64'd0);
        end
        @(posedge clk); #1;
        f_req = 1'b0;

        // Load image word, then boot_done with a loader read in the same cycle.
        do_load(1'b1, 5'd5, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        boot_done = 1'b1; l_req = 1'b1; l_we = 1'b0; l_addr = 5'd5;
        @(negedge clk);
        chk("bootdone_l_gnt", 64'(l_gnt_a[0]), 64'd1);
        chk("bootdone_running", 64'(running_a[0]), 64'd0);
        @(posedge clk); #1;
        boot_done = 1'b0; l_req = 1'b0;
        f_req = 1'b1; f_addr = 5'd5;
        @(negedge clk);
        chk("run_running", 64'(running_a[0]), 64'd1);
        chk("run_first_f_gnt", 64'(f_gnt_a[0]), 64'd1);
        @(posedge clk); #1;
        f_req = 1'b0;
        @(negedge clk);
        chk("first_fetch_rvalid", 64'(f_rvalid_a[0]), 64'd1);
        chk("first_fetch_rdata", 64'(f_rdata_a[0]), 64'hDEAD_BEEF);
        chk("first_fetch_no_lrvalid", 64'(l_rvalid_a[0]), 64'd0);
        idle(3);

        // Starvation guard: both requesting continuously.
        @(posedge clk); #1;
        f_req = 1'b1; f_addr = 5'd7; l_req = 1'b1; l_we = 1'b0; l_addr = 5'd2;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk($sformatf("starve_l_gnt_c%0d", i), 64'(l_gnt_a[0]), 64'((i % 5) == 4));
            chk($sformatf("starve_f_gnt_c%0d", i), 64'(f_gnt_a[0]), 64'((i % 5) != 4));
        end
        @(posedge clk); #1;
        f_req = 1'b0; l_req = 1'b0;
        idle(4);

        // Alternating back-to-back reads F1 L2 F3 L4, twice; no gaps.
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            f_req = 1'b0; l_req = 1'b0;
            if (i < 8) begin
                if (i % 2 == 0) begin
                    f_req = 1'b1; f_addr = AW'((i % 4) + 1);
                end else begin
                    l_req = 1'b1; l_we = 1'b0; l_addr = AW'((i % 4) + 1);
                end
            end
            @(negedge clk);
            if (i < 8) chk("alt_gnt", 64'(i % 2 == 0 ? f_gnt_a[0] : l_gnt_a[0]), 64'd1);
            chk($sformatf("alt_busy1_c%0d", i), 64'(f_rvalid_a[0] | l_rvalid_a[0]),
                64'(i >= 1 && i <= 8));
            chk($sformatf("alt_busy2_c%0d", i), 64'(f_rvalid_a[1] | l_rvalid_a[1]),
                64'(i >= 2 && i <= 9));
        end
        idle(2);

        // Reset one cycle after a fetch grant: that read must never return.
        @(posedge clk); #1;
        f_req = 1'b1; f_addr = 5'd1;
        @(negedge clk);
        chk("midrst_f_gnt", 64'(f_gnt_a[0]), 64'd1);
        @(posedge clk); #1;
        f_req = 1'b0;
        rst = 1'b0;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_rvalid", 64'({f_rvalid_a[0], f_rvalid_a[1]}), 64'd0);
            chk("midrst_running", 64'(running_a[0]), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_rvalid", 64'({f_rvalid_a[0], f_rvalid_a[1]}), 64'd0);
            chk("postrst_running", 64'(running_a[0]), 64'd0);
        end
        @(posedge clk); #1;
        boot_done = 1'b1;
        @(posedge clk); #1;
        boot_done = 1'b0;
        @(negedge clk);
        chk("reboot_running", 64'(running_a[0]), 64'd1);

        // Loader write in RUN wins after 4 fetches, then counter restarts.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            f_req = 1'b1; f_addr = (i < 5) ? 5'd6 : 5'd9;
            l_req = 1'b1; l_we = (i < 5); l_addr = 5'd9; l_wdata = 32'h1234_5678;
            @(negedge clk);
            chk($sformatf("wr_l_gnt_c%0d", i), 64'(l_gnt_a[0]), 64'(i == 4 || i == 9));
            chk($sformatf("wr_f_gnt_c%0d", i), 64'(f_gnt_a[0]), 64'(i != 4 && i != 9));
            if (i == 4) chk("wr_mem_we", 64'(mem_we_a[0]), 64'd1);
            if (i == 5) chk("wr_no_l_rvalid", 64'(l_rvalid_a[0]), 64'd0);
        end
        @(posedge clk); #1;
        f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
        idle(5);

        chk("sb_empty1", 64'(q0.size()), 64'd0);
        chk("sb_empty2", 64'(q1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
